multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel programmable timer on the bus of the MIPS microsystem, the successor to the single-channel `counter` device. Each of CHANNELS independent down-counters has its own control, preset, count and status registers. Each channel supports one-shot and auto-reload modes, a per-channel interrupt mask and a write-1-to-clear pending flag. The bridge reads and writes the registers word-addressed, and the block drives a per-channel interrupt vector plus a combined `irq` into CP0.

## Interface
- `CHANNELS`, 2, number of timer channels (1..8).
- `WIDTH`, 32, counter/preset width in bits (8..32); registers zero-extend to 32 on read.
- `AW`, $clog2(CHANNELS)+2, word-address width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  AW  word address; `addr[1:0]` selects the register, `addr[AW-1:2]` selects the channel.
- `we`  in  1  write strobe, sampled at rising edge.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr`.
- `irq_vec`  out  CHANNELS  per-channel `pending & IM`.
- `irq`  out  1  OR-reduction of `irq_vec`.

## Operation
- Register map per channel:
  - 0 = CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 = PRESET: WIDTH bits.
  - 2 = COUNT: read-only.
  - 3 = STATUS: [0] PEND, write 1 to clear.
- MODE encodings: 00 one-shot, 01 auto-reload. 10 and 11 are reserved and behave as one-shot.
- Channel index ≥ CHANNELS: reads return 0, writes are ignored.
- Per-channel FSM:
  - IDLE: go to LOAD when EN=1.
  - LOAD: COUNT←PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT>1, COUNT−1. Else COUNT←0, PEND←1, go to INT.
  - INT: in one-shot mode, EN←0 and go to IDLE. In auto-reload mode, go to LOAD.
- PRESET=0 behaves like PRESET=1.
- A write to PRESET while counting takes effect only at the next LOAD.
- A write to COUNT has no effect.
- Simultaneous STATUS W1C and hardware PEND set in the same cycle: the set wins.
- Simultaneous software CTRL write and INT one-shot EN clear in the same cycle: the software write wins.

## Timing
- Reset values: all CTRL/PRESET/COUNT/STATUS = 0, all FSMs in IDLE, `irq_vec`=0, `irq`=0. `dout` follows the reset registers.
- Reset asserted mid-count takes effect at the next edge and returns every channel to reset values.
- Writes are visible on `dout` in the cycle after the write edge.
- Enable at edge E0 (CTRL write with EN=1): LOAD at E1, COUNT=P after E2, PEND=1 after edge E0+P+2.
- `irq_vec`/`irq` are combinational from PEND and IM, so they are valid in the same cycle PEND is set.
- Auto-reload period: PEND sets every P+2 cycles.
- PEND stays set until cleared by software, independent of mode.
- Clearing IM masks the interrupt output but leaves PEND unchanged.
- Counter arithmetic is modulo 2^WIDTH. COUNT never wraps below 0.

## Structure
- Package `timer_pkg`: register offsets (`REG_CTRL`..`REG_STATUS`), MODE encodings, CTRL bit positions, FSM state enum (IDLE/LOAD/CNT/INT).
- Sub-module `timer_channel`: one FSM, its registers and PEND logic, with a local write-enable and a 32-bit read mux.
- `multi_timer` generates CHANNELS instances, decodes the channel and register from `addr`, muxes `dout`, and ORs `irq`.

## Test plan
- Reset: write junk to all registers, assert `rst` for one cycle → all reads 0, `irq`=0, ch0 COUNT stays 0 over 10 cycles.
- One-shot: ch0 PRESET=5, CTRL=0x9 at E0 → PEND=1 and `irq`=1 after E7; CTRL reads 0x8; COUNT=0; after a STATUS write of 1, `irq`=0.
- Auto-reload: ch1 PRESET=3, CTRL=0xB; clear PEND each time it sets → PEND sets every 5 cycles over 4 periods; ch0 stays untouched.
- Mask and race: IM=0 gives PEND=1 with `irq`=0. STATUS W1C on the same edge as the expiry → PEND=1.
- Disable mid-count: PRESET=10, clear EN after 4 counting cycles → COUNT frozen at 6; re-enabling reloads 10.
- Bounds with CHANNELS=3: reads of channel 3 return 0 and writes to it are ignored. WIDTH=8 with PRESET=0x1FF → PRESET reads 0xFF.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, MODE
// encodings, CTRL bit positions and the per-channel FSM state type.
package timer_pkg;

    // Register offsets within a channel (addr[1:0])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // MODE encodings; the two reserved codes fall through to one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, the
// IDLE/LOAD/CNT/INT sequencer, the pending flag and a 32-bit read mux.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] din,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t             state;
    state_t             state_next;

    logic               en;
    logic [1:0]         mode;
    logic               im;
    logic [WIDTH-1:0]   preset;
    logic [WIDTH-1:0]   count;
    logic               pend;

    logic               do_load;
    logic               do_dec;
    logic               do_expire;
    logic               do_en_clr;

    // Upper write-data bits are not stored when WIDTH < 32
    logic               unused_din;
    assign unused_din = ^din;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_expire  = 1'b0;
        do_en_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = LOAD;
            end
            LOAD: begin
                do_load    = 1'b1;
                state_next = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count > WIDTH'(1)) begin
                    do_dec = 1'b1;
                end else begin
                    // A loaded zero expires on the same edge as a loaded one
                    do_expire  = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                if (mode == MODE_AUTO) begin
                    state_next = LOAD;
                end else begin
                    do_en_clr  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registers: counter, control, preset and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            if (do_load)        count <= preset;
            else if (do_dec)    count <= count - WIDTH'(1);
            else if (do_expire) count <= '0;

            // Software CTRL write is ordered after the one-shot clear so it wins
            if (do_en_clr) en <= 1'b0;
            if (we && sel == REG_CTRL) begin
                en   <= din[CTRL_EN];
                mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= din[CTRL_IM];
            end

            // New preset is only picked up by the next LOAD
            if (we && sel == REG_PRESET) preset <= din[WIDTH-1:0];

            // Hardware set is ordered after the W1C so it wins
            if (we && sel == REG_STATUS && din[0]) pend <= 1'b0;
            if (do_expire) pend <= 1'b1;
        end
    end

    // Read mux, zero-extended to 32 bits
    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:   rdata = {28'd0, im, mode, en};
            REG_PRESET: rdata = 32'(preset);
            REG_COUNT:  rdata = 32'(count);
            REG_STATUS: rdata = {31'd0, pend};
            default:    rdata = '0;
        endcase
    end

    assign irq = pend & im;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable timer: decodes channel/register from the word
// address, instantiates CHANNELS timer channels, muxes read data and ORs
// the per-channel interrupts into irq.
module multi_timer
    import timer_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32,
    parameter int AW       = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    input  logic                we,
    input  logic [31:0]         din,
    output logic [31:0]         dout,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                irq
);

    logic [31:0] ch_idx;
    logic [1:0]  sel;
    logic [31:0] rdata [CHANNELS];

    // Shift rather than slice so a single-channel build (AW=2) still works
    assign ch_idx = 32'(addr >> 2);
    assign sel    = addr[1:0];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .we    (we && (ch_idx == 32'(i))),
            .sel   (sel),
            .din   (din),
            .rdata (rdata[i]),
            .irq   (irq_vec[i])
        );
    end

    // Read-data mux; channel indices beyond CHANNELS read as zero
    always_comb begin
        dout = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_idx == 32'(i)) dout = rdata[i];
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (3 channels, 8-bit counters): directed scenarios with
// literal expectations, then random register traffic, all compared every
// cycle against a timestamp-based behavioural model.
module tb_multi_timer;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int AW   = $clog2(CH) + 2;
    localparam int MASK = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   addr = '0;
    logic            we = 1'b0;
    logic [31:0]     din = '0;
    logic [31:0]     dout;
    logic [CH-1:0]   irq_vec;
    logic            irq;

    multi_timer #(
        .CHANNELS (CH),
        .WIDTH    (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .dout    (dout),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by timestamps (edge indices) at which things
    // happen: when the preset is loaded, when it expires, and when the
    // post-expiry action (reload or one-shot disable) takes place. COUNT is
    // derived arithmetically from the load time.
    int  n = 0;
    bit  model_on = 0;
    int  m_en [CH], m_mode [CH], m_im [CH], m_preset [CH], m_count [CH], m_pend [CH];
    int  m_idle [CH], m_counting [CH], m_base [CH];
    int  load_at [CH], t_load [CH], exp_at [CH], post_at [CH];

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
            m_count[c] = 0; m_pend[c] = 0; m_idle[c] = 1; m_counting[c] = 0;
            m_base[c] = 0; load_at[c] = -1; t_load[c] = -1; exp_at[c] = -1; post_at[c] = -1;
        end
    endfunction

    function automatic void model_edge(input logic r, input logic w,
                                       input logic [AW-1:0] a, input logic [31:0] d);
        if (r) begin
            model_reset();
            model_on = 1;
            return;
        end
        for (int c = 0; c < CH; c++) begin
            bit set_p  = 0;
            bit clr_en = 0;
            if (m_idle[c] != 0) begin
                if (m_en[c] != 0) begin
                    m_idle[c] = 0;
                    load_at[c] = n + 1;
                end
            end else if (m_counting[c] != 0) begin
                if (m_en[c] == 0) begin
                    m_counting[c] = 0;
                    m_idle[c] = 1;
                end else if (n == exp_at[c]) begin
                    m_count[c] = 0;
                    set_p = 1;
                    m_counting[c] = 0;
                    post_at[c] = n + 1;
                end else begin
                    m_count[c] = (m_base[c] - (n - t_load[c])) & MASK;
                end
            end else if (n == load_at[c]) begin
                m_base[c]  = m_preset[c];
                m_count[c] = m_preset[c];
                t_load[c]  = n;
                exp_at[c]  = n + ((m_preset[c] == 0) ? 1 : m_preset[c]);
                m_counting[c] = 1;
                load_at[c] = -1;
            end else if (n == post_at[c]) begin
                post_at[c] = -1;
                if (m_mode[c] == 1) begin
                    load_at[c] = n + 1;
                end else begin
                    clr_en = 1;
                    m_idle[c] = 1;
                end
            end
            if (clr_en) m_en[c] = 0;
            if (w && (int'(a) >> 2) == c) begin
                case (a[1:0])
                    2'd0: begin
                        m_en[c]   = int'(d[0]);
                        m_mode[c] = int'(d[2:1]);
                        m_im[c]   = int'(d[3]);
                    end
                    2'd1: m_preset[c] = int'(d) & MASK;
                    2'd3: if (d[0]) m_pend[c] = 0;
                    default: ;
                endcase
            end
            if (set_p) m_pend[c] = 1;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int c;
        c = int'(a) >> 2;
        if (c >= CH) return 32'd0;
        case (a[1:0])
            2'd0: return 32'((m_im[c] << 3) | (m_mode[c] << 1) | m_en[c]);
            2'd1: return 32'(m_preset[c]);
            2'd2: return 32'(m_count[c]);
            default: return 32'(m_pend[c]);
        endcase
    endfunction

    function automatic logic [CH-1:0] model_irq_vec();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (m_pend[c] != 0) && (m_im[c] != 0);
        return v;
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_on) begin
            check("irq_vec", 32'(irq_vec), 32'(model_irq_vec()));
            check("irq", 32'(irq), 32'(|model_irq_vec()));
            check("dout", dout, model_read(addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        logic r, w;
        logic [AW-1:0] a;
        logic [31:0] d;
        r = rst; w = we; a = addr; d = din;
        @(posedge clk);
        #1;
        model_edge(r, w, a, d);
        n++;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1; addr = AW'(a); din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_check(input string name, input int a, input logic [31:0] exp);
        addr = AW'(a);
        #1;
        check(name, dout, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, prev, found, r, a;
        logic [31:0] d;

        // Power-on reset
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset: junk everywhere, one reset cycle, everything reads 0
        for (int i = 0; i < 4 * CH; i++) wr(i, $urandom);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) rd_check("reset_read", i, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        addr = AW'(2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_count_hold", dout, 32'd0);
        end

        // One-shot ch0, PRESET=5, enabled at E0: PEND at E7
        wr(1, 32'd5);
        wr(0, 32'h9);
        repeat (6) tick();
        check("oneshot_irq_before", 32'(irq), 32'd0);
        tick();
        check("oneshot_irq_at_e7", 32'(irq), 32'd1);
        tick();
        rd_check("oneshot_ctrl", 0, 32'h8);
        rd_check("oneshot_count", 2, 32'd0);
        wr(3, 32'd1);
        check("oneshot_irq_cleared", 32'(irq), 32'd0);

        // Auto-reload ch1, PRESET=3: PEND every 5 cycles
        wr(5, 32'd3);
        wr(4, 32'hB);
        e0 = n - 1;
        prev = e0;
        for (int p = 0; p < 4; p++) begin
            found = 0;
            for (int k = 0; k < 20 && found == 0; k++) begin
                tick();
                if (irq_vec[1]) found = 1;
            end
            check("autoreload_found", 32'(found), 32'd1);
            check("autoreload_period", 32'((n - 1) - prev), 32'd5);
            prev = n - 1;
            wr(7, 32'd1);
        end
        rd_check("ch0_untouched_ctrl", 0, 32'h8);
        rd_check("ch0_untouched_status", 3, 32'd0);
        wr(4, 32'd0);
        repeat (3) tick();
        wr(7, 32'd1);

        // Mask: IM=0 still sets PEND but keeps irq low
        wr(1, 32'd2);
        wr(0, 32'h1);
        repeat (4) tick();
        rd_check("mask_pend", 3, 32'd1);
        check("mask_irq", 32'(irq), 32'd0);
        tick();
        wr(3, 32'd1);

        // Race: W1C on the expiry edge loses; CTRL write on the disable edge wins
        wr(1, 32'd3);
        wr(0, 32'h9);
        repeat (4) tick();
        wr(3, 32'd1);
        rd_check("race_w1c_pend", 3, 32'd1);
        check("race_w1c_irq", 32'(irq), 32'd1);
        wr(0, 32'h9);
        rd_check("race_ctrl_wins", 0, 32'h9);
        wr(0, 32'h0);
        repeat (3) tick();
        wr(3, 32'd1);

        // Disable mid-count: COUNT frozen at 6, re-enable reloads 10
        wr(1, 32'd10);
        wr(0, 32'h1);
        repeat (5) tick();
        wr(0, 32'h0);
        repeat (3) tick();
        rd_check("disable_frozen", 2, 32'd6);
        wr(0, 32'h1);
        repeat (2) tick();
        rd_check("reenable_reload", 2, 32'd10);
        wr(0, 32'h0);
        repeat (3) tick();

        // Bounds: channel 3 reads 0 and ignores writes; PRESET truncates to WIDTH
        for (int i = 12; i < 16; i++) rd_check("oob_read", i, 32'd0);
        for (int i = 12; i < 16; i++) wr(i, 32'hFFFF_FFFF);
        for (int i = 12; i < 16; i++) rd_check("oob_after_write", i, 32'd0);
        wr(9, 32'h1FF);
        rd_check("preset_trunc", 9, 32'hFF);

        // PRESET=0 behaves like PRESET=1: PEND at E3
        wr(9, 32'd0);
        wr(8, 32'h9);
        repeat (2) tick();
        check("preset0_before", 32'(irq_vec[2]), 32'd0);
        tick();
        check("preset0_at_e3", 32'(irq_vec[2]), 32'd1);
        tick();
        wr(11, 32'd1);

        // Random register traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if (r < 60) begin
                a = $urandom_range(0, 15);
                case (a % 4)
                    0: d = {$urandom_range(0, 1) == 0 ? 28'd0 : 28'($urandom), 4'($urandom_range(0, 15))};
                    1: d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 10));
                    default: d = $urandom;
                endcase
                wr(a, d);
            end else begin
                addr = AW'($urandom_range(0, 15));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
